uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_byte_fifo.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART receiver definitions.
//   UART_CLKS_PER_BIT_DEFAULT : default clk_50M cycles per bit (500 kbps)
//   rx_state_e                : receiver FSM states
//   rx_push_t                 : byte hand-off from the receiver to storage
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 100;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } rx_push_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo -- DEPTH-entry byte FIFO, head shown combinationally.
//   clk_50M, rst_n : clock, synchronous active-low reset
//   push/push_data : write request; accepted when not full, or when full
//                    together with a pop
//   pop            : read request; ignored when empty
//   pop_data       : head entry (0 when empty)
//   full/empty     : occupancy flags
//   count          : occupied entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign wr_en    = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign pop_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk_50M) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- 8N1 UART receiver with receive buffer.
//   clk_50M     : system clock, all logic on rising edge
//   rst_n       : synchronous active-low reset
//   uart_rx_pin : asynchronous serial line, idle high
//   rx_byte     : buffer head, valid while rx_valid
//   rx_valid    : buffer not empty
//   rx_ready    : consumer pop request (pop = rx_valid & rx_ready)
//   frame_error : 1-cycle pulse per frame with a low stop bit
//   overflow    : 1-cycle pulse per byte dropped on a full buffer
//   fifo_count  : occupied entries
// Build option: UART_RX_FIFO_EN defined -> FIFO_DEPTH-entry uart_byte_fifo;
// undefined -> single holding register (depth 1, FIFO_DEPTH ignored).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic                          uart_rx_pin,
  output logic [7:0]                    rx_byte,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_error,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              CW       = $clog2(CLKS_PER_BIT + 1);
  localparam int              CNTW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [1:0]    fill;
  logic          armed;
  rx_state_e     state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  rx_push_t      push_req;
  logic          pop, full, empty;

  assign rx_s          = sync_q[1];
  assign push_req.vld  = (state == ST_STOP) && (clk_cnt == BIT_END) && rx_s;
  assign push_req.data = shreg;
  assign rx_valid      = !empty;
  assign pop           = rx_valid && rx_ready;

  // fill marks when the synchronizer holds real pin samples again after
  // reset (its preset 1s are not evidence of an idle line). armed records
  // that the line has been seen high since reset: a low line before that is
  // the tail of an abandoned frame, so it is skipped via WAIT_HIGH.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      fill        <= 2'b00;
      armed       <= 1'b0;
      state       <= ST_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], uart_rx_pin};
      fill        <= {fill[0], 1'b1};
      frame_error <= 1'b0;
      overflow    <= push_req.vld && full && !pop;
      if (fill[1] && rx_s) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (fill[1] && !rx_s) begin
            state   <= armed ? ST_START : ST_WAIT_HIGH;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (clk_cnt == HALF_END) begin
            state   <= rx_s ? ST_IDLE : ST_DATA;  // high = glitch
            clk_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (clk_cnt == BIT_END) begin
            shreg   <= {rx_s, shreg[7:1]};        // LSB first
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (clk_cnt == BIT_END) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= ST_WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_WAIT_HIGH: if (rx_s) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .push      (push_req.vld),
    .push_data (push_req.data),
    .pop       (pop),
    .pop_data  (rx_byte),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );
`else
  logic       hold_vld;
  logic [7:0] hold_data;

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_data <= 8'h00;
    end else if (push_req.vld && (!hold_vld || pop)) begin
      hold_vld  <= 1'b1;
      hold_data <= push_req.data;
    end else if (pop) begin
      hold_vld  <= 1'b0;
    end
  end

  assign full       = hold_vld;
  assign empty      = !hold_vld;
  assign rx_byte    = hold_vld ? hold_data : 8'h00;
  assign fifo_count = CNTW'(hold_vld);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- directed frames against a queue model of the receive
// buffer. Each frame sent schedules its expected outcome (push or frame
// error) at the stop-bit sample edge; a negedge process advances the model
// and compares every output each cycle.
module tb_uart_rx_fifo;

  localparam int CPB = 100;
  // Edges from the pin falling to the stop-bit sample: 2 synchronizer flops,
  // 1 cycle for IDLE to see the low level, half a bit to the start centre,
  // then 9 bit periods (8 data + stop).
  localparam int LAT = 3 + CPB/2 + 9*CPB;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx_pin = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_error, overflow;
  logic [3:0] fifo_count;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk_50M     (clk_50M),
    .rst_n       (rst_n),
    .uart_rx_pin (uart_rx_pin),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct {
    int unsigned edge_n;
    bit          good;
    logic [7:0]  data;
  } ev_t;

  ev_t         sched[$];
  logic [7:0]  mq[$];
  logic [7:0]  got[$];
  int unsigned cyc = 0;
  int          checks = 0, errors = 0;
  int          fe_seen = 0, ov_seen = 0, maxc = 0;
  bit          track = 0, rst_prev = 0, rdy_prev = 0, exp_fe = 0, exp_ov = 0;

  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model step for the edge that just passed, then compare.
  always @(negedge clk_50M) begin : model
    bit pop_e, push_e, bad_e;
    logic [7:0] d;
    pop_e = 0; push_e = 0; bad_e = 0; d = 8'h00;
    if (!rst_prev) begin
      mq.delete();
      exp_fe = 0;
      exp_ov = 0;
    end else begin
      if (sched.size() > 0 && sched[0].edge_n == cyc) begin
        push_e = sched[0].good;
        bad_e  = !sched[0].good;
        d      = sched[0].data;
        void'(sched.pop_front());
      end
      pop_e  = (mq.size() > 0) && rdy_prev;
      exp_fe = bad_e;
      exp_ov = push_e && (mq.size() == DEPTH) && !pop_e;
      if (pop_e) void'(mq.pop_front());
      if (push_e && !exp_ov) mq.push_back(d);
    end
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("rx_valid", int'(rx_valid), int'(mq.size() > 0));
    if (mq.size() > 0) chk("rx_byte", int'(rx_byte), int'(mq[0]));
    else if (!rst_prev) chk("rx_byte_in_reset", int'(rx_byte), 0);
    chk("frame_error", int'(frame_error), int'(exp_fe));
    chk("overflow", int'(overflow), int'(exp_ov));
    if (rx_valid && rx_ready) got.push_back(rx_byte);
    fe_seen += int'(frame_error);
    ov_seen += int'(overflow);
    if (track && int'(fifo_count) > maxc) maxc = int'(fifo_count);
    rst_prev = rst_n;
    rdy_prev = rx_ready;
  end

  // All drivers enter and leave 1 time unit after a rising edge.
  task automatic drive_bit(input logic v, input int n);
    uart_rx_pin = v;
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v = 1'b1,
                      input int stop_n = CPB);
    ev_t e;
    e.edge_n = cyc + LAT;
    e.good   = stop_v;
    e.data   = b;
    sched.push_back(e);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop_v, stop_n);
    uart_rx_pin = 1'b1;
  endtask

  function automatic int last_got();
    return (got.size() > 0) ? int'(got[got.size()-1]) : -1;
  endfunction

  initial begin
    int n0, fe0;
    repeat (5) @(posedge clk_50M);
    #1;
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_valid", int'(rx_valid), 0);
    rst_n = 1'b1;
    idle(20);

    // single frame
    send(8'hA5);
    idle(20);
    chk("a5_count", got.size(), 1);
    chk("a5_byte", last_got(), 'hA5);
    chk("a5_fe", fe_seen, 0);
    chk("a5_ov", ov_seen, 0);

    // 30-cycle glitch, then a good frame
    drive_bit(1'b0, 30);
    idle(200);
    chk("glitch_nobyte", got.size(), 1);
    chk("glitch_nofe", fe_seen, 0);
    send(8'h3C);
    idle(20);
    chk("3c_byte", last_got(), 'h3C);

    // low stop bit held 300 cycles, then a good frame
    send(8'h55, 1'b0, 300);
    idle(50);
    chk("fe_once", fe_seen, 1);
    chk("fe_nopush", got.size(), 2);
    send(8'h81);
    idle(20);
    chk("81_byte", last_got(), 'h81);

    // back-to-back with rx_ready=1
    track = 1; maxc = 0;
    send(8'h11); send(8'h22); send(8'h33);
    idle(20);
    track = 0;
    chk("b2b_count", got.size(), 6);
    chk("b2b_0", int'(got[3]), 'h11);
    chk("b2b_1", int'(got[4]), 'h22);
    chk("b2b_2", int'(got[5]), 'h33);
    chk("b2b_max_le1", int'(maxc <= 1), 1);

    // fill with rx_ready=0, then drain
    rx_ready = 1'b0;
    for (int k = 1; k <= 9; k++) send(8'(k));
    idle(20);
    chk("full_count", int'(fifo_count), DEPTH);
    chk("full_ov", ov_seen, 9 - DEPTH);
    n0 = got.size();
    rx_ready = 1'b1;
    idle(20);
    chk("drain_n", got.size() - n0, DEPTH);
    for (int k = 0; k < DEPTH; k++)
      if (n0 + k < got.size()) chk("drain_order", int'(got[n0+k]), k + 1);
    chk("drain_empty", int'(rx_valid), 0);

    // reset in the middle of bit 3 of 0xF0
    n0 = got.size(); fe0 = fe_seen;
    fork
      send(8'hF0);
      begin
        repeat (4*CPB + CPB/2) @(posedge clk_50M);
        #1;
        rst_n = 1'b0;
        sched.delete();
        repeat (3) @(posedge clk_50M);
        #1;
        rst_n = 1'b1;
      end
    join
    idle(50);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_nobyte", got.size(), n0);
    chk("rst_nofe", fe_seen, fe0);
    send(8'h0F);
    idle(20);
    chk("0f_n", got.size(), n0 + 1);
    chk("0f_byte", last_got(), 'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
